axis_spi_burst_master: RTL

AXIS_SPI_BURST_MASTER -- requirements
Module: axis_spi_burst_master

---
 rtl/axis_spi_pkg.sv | 18 +
 rtl/spi_clk_gen.sv | 49 ++++
 rtl/axis_spi_burst_master.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/axis_spi_pkg.sv
// rtl/axis_spi_pkg.sv - shared FSM state and SPI mode types for the AXIS SPI burst master
package axis_spi_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      SHIFT = 3'd2,
      NEXT  = 3'd3,
      GAP   = 3'd4
   } state_t;

   typedef struct packed {
      logic cpol;
      logic cpha;
      logic lsb_first;
   } mode_t;

endpackage

// File: rtl/spi_clk_gen.sv
// rtl/spi_clk_gen.sv - half-period tick and SCLK toggle index generator
// Counts are cleared whenever run_i is low, so every word starts from toggle 0.
module spi_clk_gen #(
   parameter int DIV     = 2,
   parameter int TOGGLES = 16,
   localparam int TW     = $clog2(TOGGLES + 1)
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          run_i,
   output logic          tick_o,
   output logic [TW-1:0] tog_o
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

   logic [CW-1:0] div_q, div_d;
   logic [TW-1:0] tog_q, tog_d;
   logic          tick;

   always_comb begin
      tick  = run_i && (div_q == CW'(DIV - 1));
      div_d = div_q;
      tog_d = tog_q;
      if (!run_i) begin
         div_d = '0;
         tog_d = '0;
      end else if (tick) begin
         div_d = '0;
         tog_d = tog_q + TW'(1);
      end else begin
         div_d = div_q + CW'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         div_q <= '0;
         tog_q <= '0;
      end else begin
         div_q <= div_d;
         tog_q <= tog_d;
      end
   end

   assign tick_o = tick;
   assign tog_o  = tog_q;

endmodule

// File: rtl/axis_spi_burst_master.sv
// rtl/axis_spi_burst_master.sv - AXI-Stream fed SPI master with multi-word chip-select bursts
// Words sharing a burst keep CS low; a burst ends on s_axis_tlast and is followed by a CS-high gap.
module axis_spi_burst_master
   import axis_spi_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int MAIN_CLK   = 27_000_000,
   parameter int SPI_CLK    = 6_750_000,
   parameter int SLAVE_NUM  = 4,
   parameter int WAIT_TIME  = 50,
   localparam int ADDR_W    = (SLAVE_NUM > 1) ? $clog2(SLAVE_NUM) : 1
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  cpol_i,
   input  logic                  cpha_i,
   input  logic                  lsb_first_i,
   input  logic [ADDR_W-1:0]     addr_i,
   output logic                  spi_clk_o,
   output logic [SLAVE_NUM-1:0]  spi_cs_o,
   output logic                  spi_mosi_o,
   input  logic                  spi_miso_i,
   input  logic [DATA_WIDTH-1:0] s_axis_tdata,
   input  logic                  s_axis_tvalid,
   output logic                  s_axis_tready,
   input  logic                  s_axis_tlast,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   output logic                  m_axis_tlast
);

   localparam int DIV     = MAIN_CLK / (2 * SPI_CLK);
   localparam int TOGGLES = 2 * DATA_WIDTH;
   localparam int TW      = $clog2(TOGGLES + 1);
   localparam int IW      = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam int GW      = (WAIT_TIME > 1) ? $clog2(WAIT_TIME + 1) : 1;

   generate
      if (DIV < 1) begin : g_div_check
         $error("axis_spi_burst_master: MAIN_CLK/(2*SPI_CLK) must be at least 1");
      end
   endgenerate

   function automatic logic [SLAVE_NUM-1:0] cs_decode(input logic [ADDR_W-1:0] a);
      logic [SLAVE_NUM-1:0] r;
      r = '1;
      for (int i = 0; i < SLAVE_NUM; i++) begin
         if (int'(a) == i) r[i] = 1'b0;
      end
      return r;
   endfunction

   function automatic logic first_bit(input logic [DATA_WIDTH-1:0] d, input logic lsb);
      return lsb ? d[0] : d[DATA_WIDTH-1];
   endfunction

   state_t                 state_q, state_d;
   mode_t                  mode_q, mode_d;
   logic [ADDR_W-1:0]      addr_q, addr_d;
   logic [DATA_WIDTH-1:0]  tx_q, tx_d;
   logic                   last_q, last_d;
   logic [DATA_WIDTH-1:0]  rx_q, rx_d;
   logic                   sclk_q, sclk_d;
   logic                   mosi_q, mosi_d;
   logic [SLAVE_NUM-1:0]   cs_q, cs_d;
   logic [GW-1:0]          gap_q, gap_d;
   logic [DATA_WIDTH-1:0]  m_data_q, m_data_d;
   logic                   m_last_q, m_last_d;
   logic                   m_valid_q, m_valid_d;

   logic                   tick;
   logic [TW-1:0]          tog;
   logic                   m_free, s_ready, s_hs;
   logic                   odd_toggle, sample, last_toggle;
   logic [TW:0]            bit_idx;
   logic [IW-1:0]          bit_sel;
   logic [DATA_WIDTH-1:0]  rx_shift;

   spi_clk_gen #(
      .DIV     (DIV),
      .TOGGLES (TOGGLES)
   ) u_clk_gen (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .run_i  (state_q == SHIFT),
      .tick_o (tick),
      .tog_o  (tog)
   );

   always_comb begin
      state_d   = state_q;
      mode_d    = mode_q;
      addr_d    = addr_q;
      tx_d      = tx_q;
      last_d    = last_q;
      rx_d      = rx_q;
      sclk_d    = sclk_q;
      mosi_d    = mosi_q;
      cs_d      = cs_q;
      gap_d     = gap_q;
      m_data_d  = m_data_q;
      m_last_d  = m_last_q;
      m_valid_d = m_valid_q;

      // A new word is only accepted when its result has somewhere to land.
      m_free  = !m_valid_q || m_axis_tready;
      s_ready = !rst_i && ((state_q == IDLE) || (state_q == NEXT)) && m_free;
      s_hs    = s_ready && s_axis_tvalid;

      odd_toggle  = ~tog[0];
      sample      = mode_q.cpha ? ~odd_toggle : odd_toggle;
      last_toggle = (tog == TW'(TOGGLES - 1));
      bit_idx     = ({1'b0, tog} + (TW + 1)'(mode_q.cpha ? 0 : 1)) >> 1;
      bit_sel     = mode_q.lsb_first ? bit_idx[IW-1:0] : IW'(DATA_WIDTH - 1) - bit_idx[IW-1:0];
      rx_shift    = mode_q.lsb_first ? {spi_miso_i, rx_q[DATA_WIDTH-1:1]}
                                     : {rx_q[DATA_WIDTH-2:0], spi_miso_i};

      if (m_valid_q && m_axis_tready) m_valid_d = 1'b0;

      case (state_q)
         IDLE: begin
            sclk_d = cpol_i;
            mosi_d = 1'b0;
            cs_d   = '1;
            if (s_hs) begin
               tx_d             = s_axis_tdata;
               last_d           = s_axis_tlast;
               addr_d           = addr_i;
               mode_d.cpol      = cpol_i;
               mode_d.cpha      = cpha_i;
               mode_d.lsb_first = lsb_first_i;
               cs_d             = cs_decode(addr_i);
               mosi_d           = first_bit(s_axis_tdata, lsb_first_i);
               state_d          = LOAD;
            end
         end
         LOAD: begin
            rx_d    = '0;
            cs_d    = cs_decode(addr_q);
            state_d = SHIFT;
         end
         SHIFT: begin
            if (tick) begin
               sclk_d = ~sclk_q;
               if (sample) begin
                  rx_d = rx_shift;
               end else if (bit_idx < (TW + 1)'(DATA_WIDTH)) begin
                  mosi_d = tx_q[bit_sel];
               end
               if (last_toggle) begin
                  m_data_d  = sample ? rx_shift : rx_q;
                  m_last_d  = last_q;
                  m_valid_d = 1'b1;
                  if (last_q) begin
                     cs_d    = '1;
                     mosi_d  = 1'b0;
                     gap_d   = '0;
                     state_d = GAP;
                  end else begin
                     state_d = NEXT;
                  end
               end
            end
         end
         NEXT: begin
            sclk_d = mode_q.cpol;
            if (s_hs) begin
               tx_d    = s_axis_tdata;
               last_d  = s_axis_tlast;
               mosi_d  = first_bit(s_axis_tdata, mode_q.lsb_first);
               state_d = LOAD;
            end
         end
         GAP: begin
            sclk_d = mode_q.cpol;
            cs_d   = '1;
            mosi_d = 1'b0;
            if (WAIT_TIME <= 1 || gap_q == GW'(WAIT_TIME - 1)) begin
               gap_d   = '0;
               state_d = IDLE;
            end else begin
               gap_d = gap_q + GW'(1);
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         mode_q    <= '0;
         addr_q    <= '0;
         tx_q      <= '0;
         last_q    <= 1'b0;
         rx_q      <= '0;
         sclk_q    <= 1'b0;
         mosi_q    <= 1'b0;
         cs_q      <= '1;
         gap_q     <= '0;
         m_data_q  <= '0;
         m_last_q  <= 1'b0;
         m_valid_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         mode_q    <= mode_d;
         addr_q    <= addr_d;
         tx_q      <= tx_d;
         last_q    <= last_d;
         rx_q      <= rx_d;
         sclk_q    <= sclk_d;
         mosi_q    <= mosi_d;
         cs_q      <= cs_d;
         gap_q     <= gap_d;
         m_data_q  <= m_data_d;
         m_last_q  <= m_last_d;
         m_valid_q <= m_valid_d;
      end
   end

   assign spi_clk_o     = sclk_q;
   assign spi_cs_o      = cs_q;
   assign spi_mosi_o    = mosi_q;
   assign s_axis_tready = s_ready;
   assign m_axis_tdata  = m_data_q;
   assign m_axis_tlast  = m_last_q;
   assign m_axis_tvalid = m_valid_q;

endmodule
